// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
package fwd_pkg;

  localparam int unsigned FWD_SEL_RF = 0;
  // Entry fields are sized for the widest supported build; narrower builds zero-extend.
  localparam int unsigned SB_RD_W    = 8;
  localparam int unsigned SB_RDY_W   = 8;

  typedef struct packed {
    logic                valid;
    logic [SB_RD_W-1:0]  rd;
    logic [SB_RDY_W-1:0] rdy_stg;
  } sb_entry_t;

  function automatic int unsigned stage_sel(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// DE-side request, operand data and forwarding result bundle for fwd_scoreboard.
interface fwd_scoreboard_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGB = 5,
  parameter int unsigned NSTG  = 3,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned SELW  = $clog2(NSTG + 1),
  parameter int unsigned CNTW  = 16
);
  logic                  DE_VALID;
  logic [NREGB-1:0]      DE_RD;
  logic                  DE_REGWRT;
  logic [SELW-1:0]       DE_RDY_STG;
  logic [NSRC*NREGB-1:0] DE_RS;
  logic [NSRC-1:0]       DE_RS_USED;
  logic                  FLUSH;
  logic [NSRC*XLEN-1:0]  RF_DATA;
  logic [NSTG*XLEN-1:0]  STG_DATA;
  logic [NSRC*SELW-1:0]  FWD_SEL;
  logic [NSRC*XLEN-1:0]  FWD_DATA;
  logic                  STALL;
  logic [CNTW-1:0]       STALL_CNT;

  modport master (
    output DE_VALID, DE_RD, DE_REGWRT, DE_RDY_STG, DE_RS, DE_RS_USED, FLUSH,
           RF_DATA, STG_DATA,
    input  FWD_SEL, FWD_DATA, STALL, STALL_CNT
  );

  modport slave (
    input  DE_VALID, DE_RD, DE_REGWRT, DE_RDY_STG, DE_RS, DE_RS_USED, FLUSH,
           RF_DATA, STG_DATA,
    output FWD_SEL, FWD_DATA, STALL, STALL_CNT
  );
endinterface

// File: rtl/fwd_scoreboard_src_select.sv
// Per-source youngest-producer match, readiness check and operand mux.
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGB = 5,
  parameter int unsigned NSTG  = 3,
  parameter int unsigned SELW  = $clog2(NSTG + 1)
) (
  input  sb_entry_t             i_sb [NSTG],
  input  logic [NREGB-1:0]      i_rs,
  input  logic                  i_used,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic [NSTG*XLEN-1:0]  i_stg_data,
  output logic [SELW-1:0]       o_sel,
  output logic [XLEN-1:0]       o_data,
  output logic                  o_not_ready
);

  logic w_found;

  // Scan from the youngest stage; the first hit masks all older producers.
  always_comb begin
    o_sel       = SELW'(FWD_SEL_RF);
    o_data      = i_rf_data;
    o_not_ready = 1'b0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      if (!w_found && i_sb[k].valid && (i_sb[k].rd == SB_RD_W'(i_rs)) &&
          (i_rs != '0) && i_used) begin
        w_found = 1'b1;
        if (k >= 32'(i_sb[k].rdy_stg)) begin
          o_sel  = SELW'(stage_sel(k));
          o_data = i_stg_data[k*XLEN +: XLEN];
        end else begin
          o_not_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight writes with per-source forwarding and stall.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGB = 5,
  parameter int unsigned NSTG  = 3,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned SELW  = $clog2(NSTG + 1),
  parameter int unsigned CNTW  = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  fwd_scoreboard_if.slave bus
);

  sb_entry_t             r_sb [NSTG];
  logic [CNTW-1:0]       r_stall_cnt;
  logic [NSRC-1:0]       w_not_ready;
  logic [NSRC*SELW-1:0]  w_sel;
  logic [NSRC*XLEN-1:0]  w_data;
  logic                  w_stall;
  logic                  w_load;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_select #(
      .XLEN  (XLEN),
      .NREGB (NREGB),
      .NSTG  (NSTG),
      .SELW  (SELW)
    ) u_src (
      .i_sb        (r_sb),
      .i_rs        (bus.DE_RS[i*NREGB +: NREGB]),
      .i_used      (bus.DE_RS_USED[i]),
      .i_rf_data   (bus.RF_DATA[i*XLEN +: XLEN]),
      .i_stg_data  (bus.STG_DATA),
      .o_sel       (w_sel[i*SELW +: SELW]),
      .o_data      (w_data[i*XLEN +: XLEN]),
      .o_not_ready (w_not_ready[i])
    );
  end

  assign w_stall = bus.DE_VALID & ~bus.FLUSH & (|w_not_ready);
  assign w_load  = bus.DE_VALID & bus.DE_REGWRT & (bus.DE_RD != '0) & ~w_stall & ~bus.FLUSH;

  assign bus.FWD_SEL   = w_sel;
  assign bus.FWD_DATA  = w_data;
  assign bus.STALL     = w_stall;
  assign bus.STALL_CNT = r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned k = 0; k < NSTG; k++) r_sb[k] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned k = 1; k < NSTG; k++) r_sb[k] <= r_sb[k-1];
      r_sb[0] <= '{valid: w_load, rd: SB_RD_W'(bus.DE_RD), rdy_stg: SB_RDY_W'(bus.DE_RDY_STG)};
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  a_rdy_legal: assert property (@(posedge CLK) disable iff (RESET)
    (bus.DE_VALID && bus.DE_REGWRT) |-> (32'(bus.DE_RDY_STG) < NSTG));

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized traffic.
module tb_fwd_scoreboard;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGB = 5;
  localparam int unsigned NSTG  = 3;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned SELW  = 2;
  localparam int unsigned CNTW  = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  fwd_scoreboard_if #(.XLEN(XLEN), .NREGB(NREGB), .NSTG(NSTG), .NSRC(NSRC),
                      .SELW(SELW), .CNTW(CNTW)) bus ();

  fwd_scoreboard #(.XLEN(XLEN), .NREGB(NREGB), .NSTG(NSTG), .NSRC(NSRC),
                   .SELW(SELW), .CNTW(CNTW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic             de_valid, de_regwrt, flush;
  int               de_rd, de_rdy;
  int               rs_v [NSRC];
  logic [NSRC-1:0]  used_v;
  logic [XLEN-1:0]  rf_v  [NSRC];
  logic [XLEN-1:0]  stg_v [NSTG];

  // Reference: list of issued writes stamped with their issue cycle.
  int q_rd [$];
  int q_rdy [$];
  int q_t [$];
  int m_cnt;

  task automatic apply();
    for (int i = 0; i < NSRC; i++) rf_v[i] = $urandom;
    for (int k = 0; k < NSTG; k++) stg_v[k] = $urandom;
    bus.DE_VALID   = de_valid;
    bus.DE_RD      = NREGB'(de_rd);
    bus.DE_REGWRT  = de_regwrt;
    bus.DE_RDY_STG = SELW'(de_rdy);
    bus.DE_RS_USED = used_v;
    bus.FLUSH      = flush;
    for (int i = 0; i < NSRC; i++) begin
      bus.DE_RS[i*NREGB +: NREGB]  = NREGB'(rs_v[i]);
      bus.RF_DATA[i*XLEN +: XLEN]  = rf_v[i];
    end
    for (int k = 0; k < NSTG; k++) bus.STG_DATA[k*XLEN +: XLEN] = stg_v[k];
    #1;
  endtask

  task automatic model_eval(output logic [NSRC*SELW-1:0] esel,
                            output logic [NSRC*XLEN-1:0] edata,
                            output logic estall);
    estall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      int best = -1;
      int brdy = 0;
      for (int j = 0; j < q_rd.size(); j++) begin
        int age = cyc - q_t[j];
        if (age < NSTG && used_v[i] && rs_v[i] != 0 && q_rd[j] == rs_v[i] &&
            (best < 0 || age < best)) begin
          best = age;
          brdy = q_rdy[j];
        end
      end
      esel[i*SELW +: SELW]  = '0;
      edata[i*XLEN +: XLEN] = rf_v[i];
      if (best >= 0) begin
        if (best >= brdy) begin
          esel[i*SELW +: SELW]  = SELW'(best + 1);
          edata[i*XLEN +: XLEN] = stg_v[best];
        end else begin
          estall = 1'b1;
        end
      end
    end
    if (!de_valid || flush) estall = 1'b0;
  endtask

  task automatic step();
    logic [NSRC*SELW-1:0] s;
    logic [NSRC*XLEN-1:0] d;
    logic st;
    int nrd [$];
    int nrdy [$];
    int nt [$];
    model_eval(s, d, st);
    @(posedge CLK);
    cyc++;
    if (RESET) begin
      q_rd.delete(); q_rdy.delete(); q_t.delete();
      m_cnt = 0;
    end else begin
      if (st && m_cnt < CNT_MAX) m_cnt++;
      if (de_valid && de_regwrt && de_rd != 0 && !st && !flush) begin
        q_rd.push_back(de_rd); q_rdy.push_back(de_rdy); q_t.push_back(cyc);
      end
    end
    for (int j = 0; j < q_rd.size(); j++) begin
      if (cyc - q_t[j] < NSTG) begin
        nrd.push_back(q_rd[j]); nrdy.push_back(q_rdy[j]); nt.push_back(q_t[j]);
      end
    end
    q_rd = nrd; q_rdy = nrdy; q_t = nt;
    apply();
  endtask

  task automatic idle();
    de_valid = 1'b0; de_regwrt = 1'b0; flush = 1'b0; de_rd = 0; de_rdy = 0;
    used_v = '0;
    for (int i = 0; i < NSRC; i++) rs_v[i] = 0;
    apply();
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < NSTG; k++) step();
  endtask

  task automatic issue(input int rd, input int rdy);
    de_valid = 1'b1; de_regwrt = 1'b1; flush = 1'b0; de_rd = rd; de_rdy = rdy;
    used_v = '0;
    apply();
  endtask

  task automatic consume(input int rs0, input int rs1, input logic [NSRC-1:0] used);
    de_valid = 1'b1; de_regwrt = 1'b0; flush = 1'b0;
    rs_v[0] = rs0; rs_v[1] = rs1; used_v = used;
    apply();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle();
    step(); step();
    RESET = 1'b0;
    consume(1, 2, 2'b11);
    total++;
    if (bus.FWD_SEL !== '0) begin
      bad++; $display("FAIL reset_sel: got %0h want 0", bus.FWD_SEL);
    end
    total++;
    if (bus.FWD_DATA !== {rf_v[1], rf_v[0]}) begin
      bad++; $display("FAIL reset_data: got %0h want %0h", bus.FWD_DATA, {rf_v[1], rf_v[0]});
    end
    total++;
    if (bus.STALL !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %0b want 0", bus.STALL);
    end
    total++;
    if (bus.STALL_CNT !== '0) begin
      bad++; $display("FAIL reset_cnt: got %0d want 0", bus.STALL_CNT);
    end
  endtask

  task automatic test_alu_fwd();
    int want_sel [4] = '{1, 2, 3, 0};
    issue(5, 0);
    step();
    consume(5, 0, 2'b01);
    for (int c = 0; c < 4; c++) begin
      logic [XLEN-1:0] want_d;
      want_d = (c < 3) ? stg_v[c] : rf_v[0];
      total++;
      if (bus.FWD_SEL[SELW-1:0] !== SELW'(want_sel[c]) || bus.FWD_DATA[XLEN-1:0] !== want_d) begin
        bad++;
        $display("FAIL alu_fwd_c%0d: got sel=%0d data=%0h want sel=%0d data=%0h",
                 c, bus.FWD_SEL[SELW-1:0], bus.FWD_DATA[XLEN-1:0], want_sel[c], want_d);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    drain();
    issue(7, 1);
    step();
    de_valid = 1'b1; de_regwrt = 1'b1; de_rd = 9; de_rdy = 0;
    rs_v[0] = 9; rs_v[1] = 7; used_v = 2'b11;
    apply();
    total++;
    if (bus.STALL !== 1'b1 || bus.FWD_SEL[2*SELW-1:SELW] !== '0) begin
      bad++; $display("FAIL load_use_stall: got stall=%0b sel1=%0d want stall=1 sel1=0",
                      bus.STALL, bus.FWD_SEL[2*SELW-1:SELW]);
    end
    step();
    total++;
    if (bus.STALL !== 1'b0 || bus.FWD_SEL[2*SELW-1:SELW] !== 2'd2 ||
        bus.FWD_DATA[2*XLEN-1:XLEN] !== stg_v[1]) begin
      bad++; $display("FAIL load_use_fwd: got stall=%0b sel1=%0d data1=%0h want 0 2 %0h",
                      bus.STALL, bus.FWD_SEL[2*SELW-1:SELW], bus.FWD_DATA[2*XLEN-1:XLEN], stg_v[1]);
    end
    total++;
    if (bus.FWD_SEL[SELW-1:0] !== '0) begin
      bad++; $display("FAIL load_use_bubble: got sel0=%0d want 0", bus.FWD_SEL[SELW-1:0]);
    end
    total++;
    if (bus.STALL_CNT !== 4'd1) begin
      bad++; $display("FAIL load_use_cnt: got %0d want 1", bus.STALL_CNT);
    end
    step();
  endtask

  task automatic test_youngest();
    drain();
    issue(3, 0); step();
    idle();      step();
    issue(3, 0); step();
    consume(3, 0, 2'b01);
    total++;
    if (bus.FWD_SEL[SELW-1:0] !== 2'd1 || bus.FWD_DATA[XLEN-1:0] !== stg_v[0]) begin
      bad++; $display("FAIL youngest: got sel0=%0d data0=%0h want 1 %0h",
                      bus.FWD_SEL[SELW-1:0], bus.FWD_DATA[XLEN-1:0], stg_v[0]);
    end
  endtask

  task automatic test_zero_and_flush();
    drain();
    issue(0, 0); step();
    consume(0, 0, 2'b11);
    total++;
    if (bus.FWD_SEL !== '0 || bus.STALL !== 1'b0) begin
      bad++; $display("FAIL zero_reg: got sel=%0h stall=%0b want 0 0", bus.FWD_SEL, bus.STALL);
    end
    issue(6, 0);
    flush = 1'b1;
    apply();
    step();
    consume(6, 0, 2'b01);
    total++;
    if (bus.FWD_SEL[SELW-1:0] !== '0) begin
      bad++; $display("FAIL flush_insert: got sel0=%0d want 0", bus.FWD_SEL[SELW-1:0]);
    end
    drain();
    issue(8, 2); step();
    consume(8, 0, 2'b01);
    flush = 1'b1;
    apply();
    total++;
    if (bus.STALL !== 1'b0) begin
      bad++; $display("FAIL flush_stall: got %0b want 0", bus.STALL);
    end
    flush = 1'b0;
    apply();
    total++;
    if (bus.STALL !== 1'b1) begin
      bad++; $display("FAIL mul_stall: got %0b want 1", bus.STALL);
    end
    drain();
  endtask

  task automatic test_saturate();
    drain();
    for (int e = 0; e < 10; e++) begin
      issue(10, 2); step();
      consume(10, 0, 2'b01);
      for (int c = 0; c < 2; c++) begin
        total++;
        if (bus.STALL !== 1'b1) begin
          bad++; $display("FAIL sat_stall_e%0d_c%0d: got %0b want 1", e, c, bus.STALL);
        end
        step();
      end
      total++;
      if (bus.STALL !== 1'b0 || bus.FWD_SEL[SELW-1:0] !== 2'd3) begin
        bad++; $display("FAIL sat_ready_e%0d: got stall=%0b sel0=%0d want 0 3",
                        e, bus.STALL, bus.FWD_SEL[SELW-1:0]);
      end
      idle(); step();
    end
    total++;
    if (bus.STALL_CNT !== 4'd15) begin
      bad++; $display("FAIL sat_cnt: got %0d want 15", bus.STALL_CNT);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    issue(11, 2); step();
    consume(11, 0, 2'b01);
    total++;
    if (bus.STALL !== 1'b1) begin
      bad++; $display("FAIL mid_pre_stall: got %0b want 1", bus.STALL);
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    apply();
    total++;
    if (bus.STALL !== 1'b0 || bus.FWD_SEL !== '0 || bus.STALL_CNT !== '0) begin
      bad++; $display("FAIL mid_reset: got stall=%0b sel=%0h cnt=%0d want 0 0 0",
                      bus.STALL, bus.FWD_SEL, bus.STALL_CNT);
    end
  endtask

  task automatic test_random();
    logic [NSRC*SELW-1:0] es;
    logic [NSRC*XLEN-1:0] ed;
    logic est;
    drain();
    for (int n = 0; n < 400; n++) begin
      RESET     = ($urandom_range(0, 99) == 0);
      de_valid  = ($urandom_range(0, 3) != 0);
      de_regwrt = $urandom_range(0, 1) == 1;
      de_rd     = $urandom_range(0, 7);
      de_rdy    = $urandom_range(0, NSTG - 1);
      flush     = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NSRC; i++) rs_v[i] = $urandom_range(0, 7);
      used_v    = NSRC'($urandom_range(0, 3));
      apply();
      model_eval(es, ed, est);
      total++;
      if (bus.FWD_SEL !== es || bus.FWD_DATA !== ed || bus.STALL !== est) begin
        bad++; $display("FAIL rand_fwd_%0d: got sel=%0h data=%0h stall=%0b want %0h %0h %0b",
                        n, bus.FWD_SEL, bus.FWD_DATA, bus.STALL, es, ed, est);
      end
      total++;
      if (bus.STALL_CNT !== CNTW'(m_cnt)) begin
        bad++; $display("FAIL rand_cnt_%0d: got %0d want %0d", n, bus.STALL_CNT, m_cnt);
      end
      step();
    end
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    m_cnt = 0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_zero_and_flush();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
